// File: rtl/nlfsr_period_bank.sv
// ---------------------------------------------------------------------------
// nlfsr_period_bank
//
// Bank of LANES independent SIZE-bit shift registers, each stepped from an
// externally supplied feedback bit, used to screen NLFSR candidates in
// batches. Every lane resolves as soon as it proves a full period, returns
// to its start state early, lands on a fixed point, or runs 2**SIZE steps
// without ever coming back. Per-lane step counts are reported as periods.
//
// Ports
//   clk            rising-edge clock for all state
//   res            asynchronous active-low reset; release is synchronised
//   start          pulse; begins a run from IDLE or DONE (ignored in RUN)
//   abort          pulse; back to IDLE from any state, results are kept
//   mode           0 = full-period check, 1 = period measurement (latched)
//   lane_en        per-lane enable mask (latched at start)
//   ena            step qualifier
//   selector_done  feedback valid; a step needs ena && selector_done
//   feedback       per-lane feedback bit, combinational from state
//   busy / done    FSM in RUN / DONE
//   found          per-lane success flag
//   failure        per-lane failure flag
//   stuck          per-lane fixed-point failure flag
//   state          lane l at [l*SIZE +: SIZE]
//   period         lane l at [l*(SIZE+1) +: SIZE+1], steps until resolution
// ---------------------------------------------------------------------------
module nlfsr_period_bank #(
  parameter int unsigned     SIZE     = 32,
  parameter int unsigned     LANES    = 4,
  parameter logic [SIZE-1:0] INIT_VAL = {1'b1, {(SIZE-1){1'b0}}}
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      mode,
  input  logic [LANES-1:0]          lane_en,
  input  logic                      ena,
  input  logic                      selector_done,
  input  logic [LANES-1:0]          feedback,
  output logic                      busy,
  output logic                      done,
  output logic [LANES-1:0]          found,
  output logic [LANES-1:0]          failure,
  output logic [LANES-1:0]          stuck,
  output logic [LANES*SIZE-1:0]     state,
  output logic [LANES*(SIZE+1)-1:0] period
);

  localparam int unsigned   PW      = SIZE + 1;
  // Maximal period of a SIZE-bit register, and the step count at which a
  // lane that never returned is declared timed out. PW bits hold both, so
  // the period counter can never wrap.
  localparam logic [PW-1:0] FULL    = {1'b0, {SIZE{1'b1}}};
  localparam logic [PW-1:0] TIMEOUT = {1'b1, {SIZE{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  // -------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release is
  // aligned to clk through two stages.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fsm_e                       fsm_q, fsm_d;
  logic                       mode_q, mode_d;
  logic [LANES-1:0]           en_q, en_d;
  logic [LANES-1:0]           found_q, found_d;
  logic [LANES-1:0]           failure_q, failure_d;
  logic [LANES-1:0]           stuck_q, stuck_d;
  logic [LANES-1:0][SIZE-1:0] lane_q, lane_d;
  logic [LANES-1:0][PW-1:0]   period_q, period_d;

  // Per-lane candidate step and the resolution it would produce.
  logic [LANES-1:0][SIZE-1:0] lane_nxt;
  logic [LANES-1:0][PW-1:0]   lane_len;
  logic [LANES-1:0]           hit_found;
  logic [LANES-1:0]           hit_fail;
  logic [LANES-1:0]           hit_stuck;
  logic [LANES-1:0]           resolved;
  logic                       all_resolved;
  logic                       step;
  logic                       start_run;

  // -------------------------------------------------------------------------
  // Per-lane next state and resolution rules, in priority order:
  // return to start, fixed point, timeout.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb block gets a default at the
  // top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_nxt  = '0;
    lane_len  = '0;
    hit_found = '0;
    hit_fail  = '0;
    hit_stuck = '0;
    resolved  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_nxt[l] = {feedback[l] ^ lane_q[l][0], lane_q[l][SIZE-1:1]};
      lane_len[l] = period_q[l] + PW'(1);

      if (lane_nxt[l] == INIT_VAL) begin
        if (mode_q || (lane_len[l] == FULL)) begin
          hit_found[l] = 1'b1;
        end else begin
          hit_fail[l] = 1'b1;
        end
      end else if (lane_nxt[l] == lane_q[l]) begin
        hit_fail[l]  = 1'b1;
        hit_stuck[l] = 1'b1;
      end else if (lane_len[l] == TIMEOUT) begin
        hit_fail[l] = 1'b1;
      end

      // Disabled lanes count as resolved with all flags clear.
      resolved[l] = !en_q[l] || found_q[l] || failure_q[l];
    end
  end

  assign all_resolved = &resolved;
  assign step         = (fsm_q == S_RUN) && ena && selector_done;
  assign start_run    = start && !abort && (fsm_q != S_RUN);

  // -------------------------------------------------------------------------
  // FSM next state and lane updates
  // -------------------------------------------------------------------------
  always_comb begin
    fsm_d     = fsm_q;
    mode_d    = mode_q;
    en_d      = en_q;
    found_d   = found_q;
    failure_d = failure_q;
    stuck_d   = stuck_q;
    lane_d    = lane_q;
    period_d  = period_q;

    if (abort) begin
      // Abort only moves the FSM; lane results stay visible in IDLE.
      fsm_d = S_IDLE;
    end else if (start_run) begin
      fsm_d     = S_RUN;
      mode_d    = mode;
      en_d      = lane_en;
      found_d   = '0;
      failure_d = '0;
      stuck_d   = '0;
      period_d  = '0;
      for (int l = 0; l < int'(LANES); l++) begin
        lane_d[l] = INIT_VAL;
      end
    end else if (fsm_q == S_RUN) begin
      // Completion is judged on registered flags, so DONE appears one edge
      // after the step that resolves the last lane.
      if (all_resolved) begin
        fsm_d = S_DONE;
      end
      for (int l = 0; l < int'(LANES); l++) begin
        if (step && !resolved[l]) begin
          lane_d[l]    = lane_nxt[l];
          period_d[l]  = lane_len[l];
          found_d[l]   = hit_found[l];
          failure_d[l] = hit_fail[l];
          stuck_d[l]   = hit_stuck[l];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      mode_q    <= 1'b0;
      en_q      <= '0;
      found_q   <= '0;
      failure_q <= '0;
      stuck_q   <= '0;
      period_q  <= '0;
      for (int l = 0; l < int'(LANES); l++) begin
        lane_q[l] <= INIT_VAL;
      end
    end else begin
      fsm_q     <= fsm_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      found_q   <= found_d;
      failure_q <= failure_d;
      stuck_q   <= stuck_d;
      period_q  <= period_d;
      lane_q    <= lane_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy    = (fsm_q == S_RUN);
  assign done    = (fsm_q == S_DONE);
  assign found   = found_q;
  assign failure = failure_q;
  assign stuck   = stuck_q;
  assign state   = lane_q;
  assign period  = period_q;

endmodule

// File: tb/tb_nlfsr_period_bank.sv
// ---------------------------------------------------------------------------
// tb_nlfsr_period_bank
//
// Bench for nlfsr_period_bank with SIZE=4, LANES=2. Each lane's feedback is
// chosen per run: 0 = constant zero (pure rotation), 1 = state[1]
// (x^4+x+1, maximal), 2 = state[0] (MSB forced to zero, reaches 0000).
// A reference model computes the expected lane results and the edge on
// which done appears; they are queued at stimulus time and popped when the
// DUT reports completion.
// ---------------------------------------------------------------------------
module tb_nlfsr_period_bank;

  localparam int SIZE  = 4;
  localparam int LANES = 2;

  typedef struct {
    logic [1:0] found;
    logic [1:0] failure;
    logic [1:0] stuck;
    logic [7:0] state;
    logic [9:0] period;
    int         done_edge;
  } exp_t;

  logic       clk;
  logic       res;
  logic       start;
  logic       abort;
  logic       mode;
  logic [1:0] lane_en;
  logic       ena;
  logic       selector_done;
  logic [1:0] feedback;
  logic       busy;
  logic       done;
  logic [1:0] found;
  logic [1:0] failure;
  logic [1:0] stuck;
  logic [7:0] state;
  logic [9:0] period;

  logic [1:0][1:0] sel;
  exp_t            sb[$];
  int              n_checks;
  int              n_errors;

  nlfsr_period_bank #(
    .SIZE (SIZE),
    .LANES(LANES)
  ) dut (
    .clk          (clk),
    .res          (res),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .lane_en      (lane_en),
    .ena          (ena),
    .selector_done(selector_done),
    .feedback     (feedback),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .failure      (failure),
    .stuck        (stuck),
    .state        (state),
    .period       (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feedback selector: combinational from the current lane state.
  always_comb begin
    feedback = '0;
    for (int l = 0; l < LANES; l++) begin
      case (sel[l])
        2'd0:    feedback[l] = 1'b0;
        2'd1:    feedback[l] = state[l*SIZE + 1];
        default: feedback[l] = state[l*SIZE];
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ena, selector_done} for qualifying-edge k of a run.
  function automatic logic [1:0] pat_drive(input int pat, input int k);
    case (pat)
      1:       return {(k % 2) == 0, 1'b1};
      2:       return {1'b1, (k % 3) != 0};
      default: return 2'b11;
    endcase
  endfunction

  // Reference model: steps each enabled lane up to `limit` steps or until it
  // resolves, then derives the edge (counted from the start edge) on which
  // done should be observed.
  function automatic exp_t model(input logic m, input logic [1:0] en,
                                 input logic [1:0] s0, input logic [1:0] s1,
                                 input int pat, input int limit);
    exp_t       e;
    int         max_steps;
    int         cnt;
    int         last;
    int         k;
    int         n;
    logic [3:0] s;
    logic [3:0] nx;
    logic [4:0] p;
    logic       fb;
    logic       fnd;
    logic       fl;
    logic       stk;
    logic [1:0] sl;
    e.found   = '0;
    e.failure = '0;
    e.stuck   = '0;
    e.state   = '0;
    e.period  = '0;
    max_steps = 0;
    for (int l = 0; l < LANES; l++) begin
      sl  = (l == 0) ? s0 : s1;
      s   = 4'b1000;
      p   = '0;
      fnd = 1'b0;
      fl  = 1'b0;
      stk = 1'b0;
      n   = 0;
      while (en[l] && !fnd && !fl && n < limit) begin
        fb = (sl == 2'd0) ? 1'b0 : (sl == 2'd1) ? s[1] : s[0];
        nx = {fb ^ s[0], s[3:1]};
        p  = p + 5'd1;
        if (nx == 4'b1000) begin
          if (m || p == 5'd15) fnd = 1'b1;
          else                 fl  = 1'b1;
        end else if (nx == s) begin
          fl  = 1'b1;
          stk = 1'b1;
        end else if (p == 5'd16) begin
          fl = 1'b1;
        end
        s = nx;
        n++;
      end
      if ((fnd || fl) && int'(p) > max_steps) max_steps = int'(p);
      e.found[l]          = fnd;
      e.failure[l]        = fl;
      e.stuck[l]          = stk;
      e.state[l*4 +: 4]   = s;
      e.period[l*5 +: 5]  = p;
    end
    cnt  = 0;
    last = 0;
    k    = 0;
    while (cnt < max_steps) begin
      k++;
      if (&pat_drive(pat, k)) begin
        cnt++;
        last = k;
      end
    end
    e.done_edge = last + 1;
    return e;
  endfunction

  task automatic compare_out(input string name, input int edge_seen, input bit chk_edge);
    exp_t e;
    check({name, "_sb_size"}, 32'(sb.size()), 32'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_found"},   32'(found),   32'(e.found));
      check({name, "_failure"}, 32'(failure), 32'(e.failure));
      check({name, "_stuck"},   32'(stuck),   32'(e.stuck));
      check({name, "_state"},   32'(state),   32'(e.state));
      check({name, "_period"},  32'(period),  32'(e.period));
      if (chk_edge) begin
        check({name, "_done_edge"}, 32'(edge_seen), 32'(e.done_edge));
        check({name, "_busy_end"},  32'(busy),      32'(0));
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_busy"},    32'(busy),                     32'(0));
    check({name, "_done"},    32'(done),                     32'(0));
    check({name, "_flags"},   32'({found, failure, stuck}),  32'(0));
    check({name, "_period"},  32'(period),                   32'(0));
    check({name, "_state"},   32'(state),                    32'(8'h88));
  endtask

  task automatic pulse_start(input logic m, input logic [1:0] en);
    mode          = m;
    lane_en       = en;
    ena           = 1'b1;
    selector_done = 1'b1;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_run(input string name, input logic m, input logic [1:0] en,
                        input logic [1:0] s0, input logic [1:0] s1, input int pat);
    int k;
    bit seen;
    sel[0] = s0;
    sel[1] = s1;
    sb.push_back(model(m, en, s0, s1, pat, 1000));
    pulse_start(m, en);
    // ena is high on the start edge, yet no step may be taken there.
    check({name, "_busy_start"},   32'(busy),                    32'(1));
    check({name, "_done_start"},   32'(done),                    32'(0));
    check({name, "_flags_start"},  32'({found, failure, stuck}), 32'(0));
    check({name, "_period_start"}, 32'(period),                  32'(0));
    check({name, "_state_start"},  32'(state),                   32'(8'h88));
    seen = 1'b0;
    for (k = 1; k <= 200; k++) begin
      {ena, selector_done} = pat_drive(pat, k);
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'(1));
    compare_out(name, k, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    res           = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    mode          = 1'b0;
    lane_en       = '0;
    ena           = 1'b0;
    selector_done = 1'b0;
    sel           = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    do_run("m0_basic",  1'b0, 2'b11, 2'd1, 2'd0, 0);
    do_run("m1_meas",   1'b1, 2'b11, 2'd1, 2'd0, 0);
    do_run("stuck",     1'b0, 2'b11, 2'd2, 2'd1, 0);
    do_run("en01_gap",  1'b0, 2'b01, 2'd1, 2'd0, 1);
    do_run("sd_gap",    1'b1, 2'b11, 2'd1, 2'd0, 2);
    do_run("all_off",   1'b0, 2'b00, 2'd1, 2'd1, 0);

    // Abort mid-run, with a start-while-busy pulse on the way that must be
    // ignored; results must hold through several IDLE edges.
    sel[0] = 2'd1;
    sel[1] = 2'd0;
    sb.push_back(model(1'b0, 2'b11, 2'd1, 2'd0, 0, 5));
    pulse_start(1'b0, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      ena           = 1'b1;
      selector_done = 1'b1;
      start         = (k == 3);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    ena   = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", 32'(busy), 32'(0));
    compare_out("abort_hold", 0, 1'b0);
    do_run("post_abort", 1'b0, 2'b11, 2'd1, 2'd0, 0);

    // Asynchronous reset in the middle of a run.
    pulse_start(1'b0, 2'b11);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
    end
    res = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_release");
    do_run("after_rst", 1'b0, 2'b11, 2'd1, 2'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nlfsr_period_bank.md
# nlfsr_period_bank

Multi-lane, parametrised NLFSR period tester. Each of LANES independent SIZE-bit shift registers is stepped from an externally supplied feedback bit. A lane resolves when it either proves a full period, returns to its start state early, gets stuck at a fixed point, or times out. Per-lane period lengths are also reported, so the bank replaces single-register checkers in the candidate search loop behind the feedback selector and supports batch screening of LANES candidates per run.

## Interface
- SIZE, 32, register width per lane (2..32)
- LANES, 4, number of independent lanes
- INIT_VAL, {1'b1,{SIZE-1{1'b0}}}, start state loaded into every lane
- localparam PW = SIZE+1, period counter width; FULL = 2**SIZE-1
- clk  in  1  clock, all state on rising edge
- res  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a run (accepted in IDLE or DONE)
- abort  in  1  pulse; returns to IDLE from any state
- mode  in  1  0 = full-period check, 1 = period measurement; latched at start
- lane_en  in  LANES  lane enable mask; latched at start
- ena  in  1  step qualifier
- selector_done  in  1  feedback valid; step occurs only when ena && selector_done
- feedback  in  LANES  per-lane feedback bit, combinational from current state
- busy  out  1  high in RUN
- done  out  1  high in DONE
- found  out  LANES  per-lane success flag
- failure  out  LANES  per-lane failure flag
- stuck  out  LANES  failure cause was a fixed point
- state  out  LANES*SIZE  lane l at [l*SIZE +: SIZE]
- period  out  LANES*PW  lane l at [l*PW +: PW], steps taken until resolution

## Operation
- FSM: IDLE -> RUN on start; RUN -> DONE when every lane is resolved; DONE -> RUN on start; any -> IDLE on abort. Abort beats start.
- On start: all lanes get state = INIT_VAL, period = 0, and found/failure/stuck = 0. Mode and lane_en are latched. Lanes with lane_en = 0 count as resolved with all flags 0.
- Step (RUN, ena && selector_done) for each unresolved lane:
  - nxt = {feedback[l]^state[l][0], state[l][SIZE-1:1]}
  - state <= nxt
  - period <= period+1 (write len = period+1)
- Resolution is evaluated on the same step with nxt and len. The first matching rule applies:
  - nxt == INIT_VAL, mode 0: found if len == FULL, else failure.
  - nxt == INIT_VAL, mode 1: found.
  - nxt == state (fixed point): failure and stuck.
  - len == 2**SIZE (timeout, never returned): failure.
- A resolved lane freezes its state, period and flags until the next start, abort or reset.
- Period arithmetic is PW bits wide and never wraps, because the timeout fires at 2**SIZE.
- In IDLE, outputs hold their last values; abort does not clear lane results.

## Timing
- Reset values: FSM = IDLE; busy = done = 0; found = failure = stuck = 0; period = 0; every lane state = INIT_VAL.
- start sampled at edge N: busy = 1 from edge N. A step is not taken at edge N even if ena && selector_done.
- One step per qualifying edge, with no pipeline: flags and period update on the same edge as state.
- done rises one edge after the edge that resolves the last lane; busy falls on that same edge.
- If all lanes are disabled, done follows start by one edge.
- start while busy is ignored.
- Gaps in ena or selector_done stall all lanes without losing state.
- res asserted mid-run clears everything immediately (asynchronous); deassertion is released synchronously to clk.

## Test plan
- SIZE=4, LANES=2, mode 0; lane0 feedback = state[1] (x^4+x+1 maximal), lane1 feedback = 0 (pure rotation). Required response:
  - lane1: failure with period 4.
  - lane0: found with period 15.
  - done one edge after step 15.
- Same feedbacks, mode 1: both lanes found, period0 = 15, period1 = 4, failure = 0.
- Lane feedback = state[0] (MSB forced 0): the lane walks 1000 -> 0100 -> 0010 -> 0001 -> 0000, then repeats 0000. Required: failure and stuck at step 5, period = 5.
- lane_en = 2'b01 with ena toggling every other cycle: only lane0 is stepped. Required:
  - lane1 keeps state 1000 and flags 0.
  - done after 15 qualifying steps, i.e. 30 cycles.
- Start and abort pulsed together mid-run: FSM returns to IDLE and busy = 0. Lane results hold; the next start clears them.
- res low at step 7: all outputs return to reset values at once; a start after release runs cleanly to period 15.
